delay_ctrl_line: RTL and testbench

//   Software-programmable sample delay line. It runs in the user_clk domain, directly downstream
//   of the PPC-to-Simulink software register, and consumes that register's 32-bit user_data_out
//   as its delay request. It delays a continuous data stream by a run-time-selected number of

---
 rtl/delay_ctrl_line_if.sv | 33 +++
 rtl/delay_ctrl_line.sv | 153 +++++++++++++++
 tb/tb_delay_ctrl_line.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/delay_ctrl_line_if.sv
// rtl/delay_ctrl_line_if.sv - register request, sample stream and status bundle for delay_ctrl_line
//
// Signals:
//   reg_value   software register word, [15:0] = requested delay
//   din         input sample, one per user_clk cycle, never stalls
//   dout        delayed sample (registered)
//   dout_valid  dout is din delayed by exactly cur_delay+1 cycles
//   cur_delay   active (clamped) delay
//   clamped     last accepted request exceeded the maximum delay
//   busy        waiting for a request or refilling the buffer
// Modports: master drives reg_value/din, slave is the delay line.

interface delay_ctrl_line_if #(
  parameter int DATA_W = 8
);
  logic [31:0]       reg_value;
  logic [DATA_W-1:0] din;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic [15:0]       cur_delay;
  logic              clamped;
  logic              busy;

  modport master (
    output reg_value, din,
    input  dout, dout_valid, cur_delay, clamped, busy
  );

  modport slave (
    input  reg_value, din,
    output dout, dout_valid, cur_delay, clamped, busy
  );
endinterface

// File: rtl/delay_ctrl_line.sv
// rtl/delay_ctrl_line.sv - software-programmable sample delay line on a circular RAM buffer
//
// Ports:
//   user_clk  only clock, rising edge
//   user_rst  synchronous active-high reset
//   bus       delay_ctrl_line_if.slave (reg_value, din in; dout, dout_valid,
//             cur_delay, clamped, busy out)
// Parameters:
//   DATA_W  sample width
//   ADDR_W  buffer address width, DEPTH = 2**ADDR_W, maximum delay DEPTH-2
//   SETTLE  consecutive identical register samples needed to accept a request (>= 2)

module delay_ctrl_line #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10,
  parameter int SETTLE = 2
) (
  input  logic               user_clk,
  input  logic               user_rst,
  delay_ctrl_line_if.slave   bus
);

  localparam int              DEPTH     = 1 << ADDR_W;
  localparam logic [15:0]     MAX_DELAY = 16'(DEPTH - 2);
  localparam int              SC_W      = $clog2(SETTLE + 1);
  localparam logic [SC_W-1:0] SETTLE_C  = SC_W'(SETTLE);

  typedef enum logic [1:0] {
    ST_WAIT = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  state_t            state, state_nxt;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;

  logic [15:0]       d_req;
  logic [15:0]       d_clamp;
  logic [15:0]       req_q;
  logic [SC_W-1:0]   stable_cnt, stable_nxt;
  logic              accept;

  logic [15:0]       cur_delay_q, cur_delay_nxt;
  logic [15:0]       fill_cnt, fill_cnt_nxt;
  logic              clamped_q, clamped_nxt;
  logic              dout_valid_q, dout_valid_nxt;
  logic [DATA_W-1:0] dout_q;

  // Upper half of the register word carries no meaning for this block.
  logic              unused_reg_hi;
  assign unused_reg_hi = ^bus.reg_value[31:16];

  assign d_req   = bus.reg_value[15:0];
  assign d_clamp = (d_req > MAX_DELAY) ? MAX_DELAY : d_req;

  // Glitch qualification: the request must sit unchanged for SETTLE
  // consecutive samples before it may touch cur_delay.
  always_comb begin
    stable_nxt = stable_cnt;
    if (d_req != req_q) begin
      stable_nxt = SC_W'(1);
    end else if (stable_cnt < SETTLE_C) begin
      stable_nxt = stable_cnt + SC_W'(1);
    end
  end

  // A settled request equal to the active delay is ignored while running,
  // so re-writing the same value never drops dout_valid.
  assign accept = (stable_nxt == SETTLE_C) &&
                  ((state == ST_WAIT) || (d_clamp != cur_delay_q));

  always_comb begin
    state_nxt      = state;
    cur_delay_nxt  = cur_delay_q;
    clamped_nxt    = clamped_q;
    fill_cnt_nxt   = fill_cnt;
    dout_valid_nxt = 1'b0;
    if (accept) begin
      // Any acceptance (including one mid-fill) restarts the fill.
      state_nxt     = ST_FILL;
      cur_delay_nxt = d_clamp;
      clamped_nxt   = (d_req > MAX_DELAY);
      fill_cnt_nxt  = d_clamp + 16'd1;
    end else begin
      case (state)
        ST_WAIT: begin
          state_nxt = ST_WAIT;
        end
        ST_FILL: begin
          if (fill_cnt == 16'd1) begin
            state_nxt      = ST_RUN;
            fill_cnt_nxt   = 16'd0;
            dout_valid_nxt = 1'b1;
          end else begin
            fill_cnt_nxt = fill_cnt - 16'd1;
          end
        end
        ST_RUN: begin
          dout_valid_nxt = 1'b1;
        end
        default: begin
          state_nxt = ST_WAIT;
        end
      endcase
    end
  end

  // Read address trails the write pointer by cur_delay. With the delay
  // capped at DEPTH-2 the only same-address case is D=0, which is served
  // by bypassing din so D=0 is a plain register stage.
  assign rd_addr = wr_ptr - cur_delay_q[ADDR_W-1:0];
  assign rd_data = (cur_delay_q == 16'd0) ? bus.din : mem[rd_addr];

  always_ff @(posedge user_clk) begin
    mem[wr_ptr] <= bus.din;
  end

  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      state        <= ST_WAIT;
      wr_ptr       <= '0;
      req_q        <= '0;
      stable_cnt   <= '0;
      cur_delay_q  <= '0;
      clamped_q    <= 1'b0;
      fill_cnt     <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      state        <= state_nxt;
      wr_ptr       <= wr_ptr + ADDR_W'(1);
      req_q        <= d_req;
      stable_cnt   <= stable_nxt;
      cur_delay_q  <= cur_delay_nxt;
      clamped_q    <= clamped_nxt;
      fill_cnt     <= fill_cnt_nxt;
      dout_valid_q <= dout_valid_nxt;
      // dout is forced to zero whenever it is not flagged valid.
      dout_q       <= dout_valid_nxt ? rd_data : '0;
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.cur_delay  = cur_delay_q;
  assign bus.clamped    = clamped_q;
  assign bus.busy       = (state != ST_RUN);

endmodule

// File: tb/tb_delay_ctrl_line.sv
// tb/tb_delay_ctrl_line.sv - table-driven bench for delay_ctrl_line

module tb_delay_ctrl_line;

  localparam int SETTLE = 2;

  logic user_clk = 1'b0;
  logic user_rst = 1'b1;

  delay_ctrl_line_if #(.DATA_W(8)) bus ();

  delay_ctrl_line #(.DATA_W(8), .ADDR_W(10), .SETTLE(SETTLE)) dut (
    .user_clk (user_clk),
    .user_rst (user_rst),
    .bus      (bus)
  );

  always #5 user_clk = ~user_clk;

  typedef struct {
    logic [31:0] reg_value;
    int          exp_d;
    bit          exp_clamped;
    int          exp_fall;   // step of first dout_valid==0, 0 = must never drop
    int          exp_rise;   // step of first dout_valid==1 after the drop
    int          run;        // steps to run for this entry
  } vec_t;

  int          checks   = 0;
  int          failures = 0;
  int unsigned cnt      = 0;
  int          model_d  = 0;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // One clock: sample just after the edge, check data whenever flagged valid,
  // then present the next counter sample.
  task automatic step();
    int unsigned e;
    @(posedge user_clk);
    #1;
    if (bus.dout_valid === 1'b1) begin
      e = cnt - int'(model_d);
      check("dout_data", int'(bus.dout), int'(e[7:0]));
    end
    cnt++;
    bus.din = cnt[7:0];
  endtask

  task automatic run_entry(input vec_t v, input string tag);
    int first_fall = 0;
    int first_rise = 0;
    bus.reg_value = v.reg_value;
    for (int i = 1; i <= v.run; i++) begin
      step();
      if (i == SETTLE) begin
        check({tag, "_cur_delay"}, int'(bus.cur_delay), v.exp_d);
        check({tag, "_clamped"}, int'(bus.clamped), int'(v.exp_clamped));
        model_d = v.exp_d;
      end
      if (first_fall == 0 && bus.dout_valid !== 1'b1) first_fall = i;
      if (first_fall != 0 && first_rise == 0 && bus.dout_valid === 1'b1) first_rise = i;
    end
    check({tag, "_fall_step"}, first_fall, v.exp_fall);
    if (v.exp_fall != 0) check({tag, "_rise_step"}, first_rise, v.exp_rise);
    check({tag, "_busy_end"}, int'(bus.busy), 0);
  endtask

  vec_t tbl[9];

  initial begin
    int dropped;
    int rise_at;

    tbl[0] = '{32'd5,          5,    1'b0, 1, 8,    30};
    tbl[1] = '{32'd100,        100,  1'b0, 2, 103,  130};
    tbl[2] = '{32'h0000_FFFF,  1022, 1'b1, 2, 1025, 2200};
    tbl[3] = '{32'd5,          5,    1'b0, 2, 8,    30};
    tbl[4] = '{32'hABCD_0005,  5,    1'b0, 0, 0,    20};
    tbl[5] = '{32'd0,          0,    1'b0, 2, 3,    20};
    tbl[6] = '{32'd1022,       1022, 1'b0, 2, 1025, 1100};
    tbl[7] = '{32'h0000_03FF,  1022, 1'b0, 0, 0,    20};
    tbl[8] = '{32'd5,          5,    1'b0, 2, 8,    30};

    bus.reg_value = 32'd5;
    bus.din       = 8'd0;
    user_rst      = 1'b1;
    for (int i = 0; i < 3; i++) step();
    check("rst_dout", int'(bus.dout), 0);
    check("rst_valid", int'(bus.dout_valid), 0);
    check("rst_cur_delay", int'(bus.cur_delay), 0);
    check("rst_clamped", int'(bus.clamped), 0);
    check("rst_busy", int'(bus.busy), 1);
    user_rst = 1'b0;

    for (int n = 0; n < 9; n++) begin
      run_entry(tbl[n], $sformatf("vec%0d", n));
    end

    // One-cycle glitch 5 -> 9 -> 5 while running at D=5.
    dropped = 0;
    bus.reg_value = 32'd9;
    step();
    if (bus.dout_valid !== 1'b1) dropped++;
    bus.reg_value = 32'd5;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus.dout_valid !== 1'b1) dropped++;
    end
    check("glitch_valid_drops", dropped, 0);
    check("glitch_cur_delay", int'(bus.cur_delay), 5);

    // Fill restart: 5 -> 50, then 50 -> 20 at fill cycle 10.
    bus.reg_value = 32'd50;
    step();
    step();
    check("fill50_cur_delay", int'(bus.cur_delay), 50);
    check("fill50_busy", int'(bus.busy), 1);
    model_d = 50;
    for (int i = 0; i < 8; i++) step();
    check("fill50_valid_mid", int'(bus.dout_valid), 0);
    bus.reg_value = 32'd20;
    step();
    step();
    check("fill20_cur_delay", int'(bus.cur_delay), 20);
    model_d = 20;
    rise_at = 0;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (rise_at == 0 && bus.dout_valid === 1'b1) rise_at = i;
    end
    check("fill20_rise_step", rise_at, 21);

    // Reset while running at D=100, then refill with a discontinuous din
    // so any pre-reset sample leaking out as valid would mismatch.
    run_entry('{32'd100, 100, 1'b0, 2, 103, 130}, "pre_rst");
    user_rst = 1'b1;
    step();
    check("midrst_dout", int'(bus.dout), 0);
    check("midrst_valid", int'(bus.dout_valid), 0);
    check("midrst_cur_delay", int'(bus.cur_delay), 0);
    check("midrst_busy", int'(bus.busy), 1);
    user_rst = 1'b0;
    cnt = cnt + 37;
    bus.din = cnt[7:0];
    run_entry('{32'd100, 100, 1'b0, 1, 103, 130}, "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
